// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_sequencer
// Brief    : Dual-channel serial ADC frame sequencer (CS/SCLK generation,
//            16-bit frame capture, valid/ack sample handshake).
//            Optional peak hold enabled by defining ADC_PEAK_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================

module adc_frame_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int QUIET_CYCLES  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        sdata0,
    input  logic        sdata1,
    input  logic        sample_ack,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample_ch0,
    output logic [11:0] sample_ch1,
    output logic        sample_valid,
    output logic        overrun,
    output logic        frame_err,
    input  logic        peak_clr,
    output logic [11:0] peak_ch0,
    output logic [11:0] peak_ch1
);

    localparam int c_PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [c_PW-1:0] c_PERIOD_LAST = c_PW'(SAMPLE_PERIOD - 1);
    localparam logic [c_DW-1:0] c_DIV_LAST    = c_DW'(CLK_DIV - 1);
    localparam logic [c_QW-1:0] c_QUIET_LAST  = c_QW'(QUIET_CYCLES - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARM   = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_QUIET = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [c_PW-1:0] r_period_cnt;
    logic [c_DW-1:0] r_div_cnt;
    logic            r_phase;
    logic [3:0]      r_bit_cnt;
    logic [c_QW-1:0] r_quiet_cnt;
    logic [15:0]     r_sr0;
    logic [15:0]     r_sr1;
    logic            r_cs_n;
    logic            r_sclk;
    logic            r_complete;
    logic [11:0]     r_sample_ch0;
    logic [11:0]     r_sample_ch1;
    logic            r_valid;
    logic            r_overrun;
    logic            r_frame_err;
    logic            w_tick;
    logic            w_last_slot;
    logic            w_cs_n_d;
    logic            w_sclk_d;
    logic            w_shift_in;

    assign w_tick      = (r_period_cnt == c_PERIOD_LAST);
    assign w_last_slot = r_phase && (r_div_cnt == c_DIV_LAST) && (r_bit_cnt == 4'd15);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_period_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + c_PW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (enable) w_next_state = c_ARM;
            c_ARM: begin
                if (!enable)     w_next_state = c_IDLE;
                else if (w_tick) w_next_state = c_SHIFT;
            end
            c_SHIFT: if (w_last_slot) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_QUIET;
            c_QUIET: if (r_quiet_cnt == c_QUIET_LAST) w_next_state = enable ? c_ARM : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Pins are registered from these, so they trail the FSM by one cycle.
    always_comb begin
        w_cs_n_d   = 1'b1;
        w_sclk_d   = 1'b1;
        w_shift_in = 1'b0;
        if (r_state == c_SHIFT) begin
            w_cs_n_d   = 1'b0;
            w_sclk_d   = r_phase;
            w_shift_in = r_phase && (r_div_cnt == '0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_bit_cnt <= 4'd0;
        end else if (r_state != c_SHIFT) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_bit_cnt <= 4'd0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            r_phase   <= !r_phase;
            if (r_phase) r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
            r_div_cnt <= r_div_cnt + c_DW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_quiet_cnt <= '0;
        end else if (r_state != c_QUIET) begin
            r_quiet_cnt <= '0;
        end else begin
            r_quiet_cnt <= r_quiet_cnt + c_QW'(1);
        end
    end

    // Data is captured on the same edge that drives the pin sclk high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr0      <= 16'd0;
            r_sr1      <= 16'd0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b1;
            r_complete <= 1'b0;
        end else begin
            if (w_shift_in) begin
                r_sr0 <= {r_sr0[14:0], sdata0};
                r_sr1 <= {r_sr1[14:0], sdata1};
            end
            r_cs_n     <= w_cs_n_d;
            r_sclk     <= w_sclk_d;
            r_complete <= (r_state == c_DONE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sample_ch0 <= 12'd0;
            r_sample_ch1 <= 12'd0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (r_complete) begin
            r_sample_ch0 <= r_sr0[11:0];
            r_sample_ch1 <= r_sr1[11:0];
            r_valid      <= 1'b1;
            r_frame_err  <= (|r_sr0[15:12]) | (|r_sr1[15:12]);
            if (r_valid && !sample_ack) r_overrun <= 1'b1;
        end else if (r_valid && sample_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

`ifdef ADC_PEAK_HOLD_EN
    logic [11:0] r_peak_ch0;
    logic [11:0] r_peak_ch1;

    // A clear coinciding with a completion restarts the hold from the new sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_peak_ch0 <= 12'd0;
            r_peak_ch1 <= 12'd0;
        end else if (r_complete) begin
            if (peak_clr || (r_sr0[11:0] > r_peak_ch0)) r_peak_ch0 <= r_sr0[11:0];
            if (peak_clr || (r_sr1[11:0] > r_peak_ch1)) r_peak_ch1 <= r_sr1[11:0];
        end else if (peak_clr) begin
            r_peak_ch0 <= 12'd0;
            r_peak_ch1 <= 12'd0;
        end
    end

    assign peak_ch0 = r_peak_ch0;
    assign peak_ch1 = r_peak_ch1;
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = peak_clr;
    assign peak_ch0          = 12'd0;
    assign peak_ch1          = 12'd0;
`endif

    assign cs_n         = r_cs_n;
    assign sclk         = r_sclk;
    assign sample_ch0   = r_sample_ch0;
    assign sample_ch1   = r_sample_ch1;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_frame_sequencer
// Brief    : Directed self-checking bench for adc_frame_sequencer with a
//            behavioural dual-channel serial ADC model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_adc_frame_sequencer;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 2500;
    localparam int QUIET_CYCLES  = 4;

    localparam logic [11:0] c_PK_S0 [4] = '{12'h100, 12'h800, 12'h300, 12'h050};
    localparam logic [11:0] c_PK_S1 [4] = '{12'h005, 12'h002, 12'h7FF, 12'h010};
`ifdef ADC_PEAK_HOLD_EN
    localparam logic [11:0] c_EXP_PK0 [4] = '{12'h100, 12'h800, 12'h800, 12'h050};
    localparam logic [11:0] c_EXP_PK1 [4] = '{12'h005, 12'h005, 12'h7FF, 12'h010};
`else
    localparam logic [11:0] c_EXP_PK0 [4] = '{12'h000, 12'h000, 12'h000, 12'h000};
    localparam logic [11:0] c_EXP_PK1 [4] = '{12'h000, 12'h000, 12'h000, 12'h000};
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        sdata0;
    logic        sdata1;
    logic        sample_ack;
    logic        peak_clr;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample_ch0;
    logic [11:0] sample_ch1;
    logic        sample_valid;
    logic        overrun;
    logic        frame_err;
    logic [11:0] peak_ch0;
    logic [11:0] peak_ch1;

    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    int          bit_idx = 15;
    logic        model_prev_sclk = 1'b1;

    int checks = 0;
    int errors = 0;

    adc_frame_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .QUIET_CYCLES  (QUIET_CYCLES)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .sdata0       (sdata0),
        .sdata1       (sdata1),
        .sample_ack   (sample_ack),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sample_ch0   (sample_ch0),
        .sample_ch1   (sample_ch1),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .peak_clr     (peak_clr),
        .peak_ch0     (peak_ch0),
        .peak_ch1     (peak_ch1)
    );

    always #5 CLK = ~CLK;

    // ADC model: MSB ready at cs_n fall, next bit presented after each sclk rise.
    always @(negedge CLK) begin
        if (cs_n !== 1'b0) bit_idx = 15;
        else if (sclk === 1'b1 && model_prev_sclk === 1'b0 && bit_idx > 0) bit_idx = bit_idx - 1;
        model_prev_sclk = sclk;
        sdata0 = word0[bit_idx];
        sdata1 = word1[bit_idx];
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ack_pulse();
        sample_ack = 1'b1;
        step(1);
        sample_ack = 1'b0;
    endtask

    task automatic wait_cs_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < SAMPLE_PERIOD + 20; i++) begin
            @(posedge CLK);
            #1;
            if (cs_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; enable = 1'b0; sample_ack = 1'b0; peak_clr = 1'b0;
        step(3);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk); end
        checks++; if (sample_ch0 !== 12'h000 || sample_ch1 !== 12'h000) begin errors++; $display("FAIL reset_samples: got %h/%h want 000/000", sample_ch0, sample_ch1); end
        checks++; if ({sample_valid, overrun, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got v/o/e=%b want 000", {sample_valid, overrun, frame_err}); end
        checks++; if (peak_ch0 !== 12'h000 || peak_ch1 !== 12'h000) begin errors++; $display("FAIL reset_peaks: got %h/%h want 000/000", peak_ch0, peak_ch1); end
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_first_frame();
        int   n, rises, cs_rise_k, valid_k, sclk_bad;
        bit   found;
        logic last_sclk, exp_sclk;
        word0 = 16'h0ABC; word1 = 16'h07FF;
        enable = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < SAMPLE_PERIOD + 50; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (cs_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found || (n - 1) != SAMPLE_PERIOD) begin errors++; $display("FAIL first_fall: got found=%0d after %0d cycles want %0d", found, n - 1, SAMPLE_PERIOD); end
        rises = 0; cs_rise_k = -1; valid_k = -1; sclk_bad = 0; last_sclk = sclk;
        for (int k = 1; k <= 135; k++) begin
            @(posedge CLK);
            #1;
            exp_sclk = ((k / CLK_DIV) % 2) == 1;
            if (k < 32 * CLK_DIV && sclk !== exp_sclk) sclk_bad++;
            if (sclk === 1'b1 && last_sclk === 1'b0) rises++;
            last_sclk = sclk;
            if (cs_rise_k < 0 && cs_n === 1'b1) cs_rise_k = k;
            if (valid_k < 0 && sample_valid === 1'b1) valid_k = k;
        end
        checks++; if (sclk_bad != 0) begin errors++; $display("FAIL sclk_duty: got %0d bad cycles want 0", sclk_bad); end
        checks++; if (rises != 16) begin errors++; $display("FAIL sclk_rises: got %0d want 16", rises); end
        checks++; if (cs_rise_k != 32 * CLK_DIV) begin errors++; $display("FAIL cs_rise: got %0d want %0d", cs_rise_k, 32 * CLK_DIV); end
        checks++; if (valid_k != 32 * CLK_DIV + 1) begin errors++; $display("FAIL valid_latency: got %0d want %0d", valid_k, 32 * CLK_DIV + 1); end
        checks++; if (sample_ch0 !== 12'hABC || sample_ch1 !== 12'h7FF) begin errors++; $display("FAIL first_data: got %h/%h want abc/7ff", sample_ch0, sample_ch1); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL first_flags: got err=%b ovr=%b want 0/0", frame_err, overrun); end
        ack_pulse();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ack_clears: got %b want 0", sample_valid); end
    endtask

    task automatic test_frame_err();
        bit ok;
        word0 = 16'h0555; word1 = 16'h4123;
        wait_cs_fall(ok);
        checks++; if (!ok) begin errors++; $display("FAIL err_frame_start: got timeout want cs_n fall"); end
        step(129);
        checks++; if (sample_valid !== 1'b1 || frame_err !== 1'b1) begin errors++; $display("FAIL err_flag: got v=%b err=%b want 1/1", sample_valid, frame_err); end
        checks++; if (sample_ch0 !== 12'h555 || sample_ch1 !== 12'h123) begin errors++; $display("FAIL err_data: got %h/%h want 555/123", sample_ch0, sample_ch1); end
        ack_pulse();
        word0 = 16'h0000; word1 = 16'h0321;
        wait_cs_fall(ok);
        step(129);
        checks++; if (sample_valid !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL err_recover: got v=%b err=%b want 1/0", sample_valid, frame_err); end
        checks++; if (sample_ch0 !== 12'h000 || sample_ch1 !== 12'h321) begin errors++; $display("FAIL clean_data: got %h/%h want 000/321", sample_ch0, sample_ch1); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        bit ok;
        word0 = 16'h0111; word1 = 16'h0222;
        wait_cs_fall(ok);
        step(129);
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got v=%b ovr=%b want 1/0", sample_valid, overrun); end
        word0 = 16'h0333; word1 = 16'h0444;
        wait_cs_fall(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_frame_start: got timeout want cs_n fall"); end
        step(129);
        checks++; if (overrun !== 1'b1 || sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_set: got ovr=%b v=%b want 1/1", overrun, sample_valid); end
        checks++; if (sample_ch0 !== 12'h333 || sample_ch1 !== 12'h444) begin errors++; $display("FAIL ovr_data: got %h/%h want 333/444", sample_ch0, sample_ch1); end
        word0 = 16'h0555; word1 = 16'h0666;
        wait_cs_fall(ok);
        step(128);
        ack_pulse();
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL coincide_ovr1: got v=%b ovr=%b want 1/1", sample_valid, overrun); end
        checks++; if (sample_ch0 !== 12'h555 || sample_ch1 !== 12'h666) begin errors++; $display("FAIL coincide_data: got %h/%h want 555/666", sample_ch0, sample_ch1); end
        ack_pulse();
        checks++; if (sample_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got v=%b ovr=%b want 0/0", sample_valid, overrun); end
        word0 = 16'h0777; word1 = 16'h0888;
        wait_cs_fall(ok);
        step(129);
        word0 = 16'h0999; word1 = 16'h0AAA;
        wait_cs_fall(ok);
        step(128);
        ack_pulse();
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL coincide_ovr0: got v=%b ovr=%b want 1/0", sample_valid, overrun); end
        checks++; if (sample_ch0 !== 12'h999 || sample_ch1 !== 12'hAAA) begin errors++; $display("FAIL coincide_data2: got %h/%h want 999/aaa", sample_ch0, sample_ch1); end
        ack_pulse();
    endtask

    task automatic test_enable_drop();
        bit   ok;
        int   rises, cs_rise_k, valid_k, lows;
        logic last_sclk;
        word0 = 16'h1ABC; word1 = 16'h0DEF;
        wait_cs_fall(ok);
        rises = 0; cs_rise_k = -1; valid_k = -1; last_sclk = sclk;
        for (int k = 1; k <= 140; k++) begin
            @(posedge CLK);
            #1;
            if (k == 36) enable = 1'b0;
            if (sclk === 1'b1 && last_sclk === 1'b0) rises++;
            last_sclk = sclk;
            if (cs_rise_k < 0 && cs_n === 1'b1) cs_rise_k = k;
            if (valid_k < 0 && sample_valid === 1'b1) valid_k = k;
        end
        checks++; if (rises != 16 || cs_rise_k != 128 || valid_k != 129) begin errors++; $display("FAIL drop_frame: got rises=%0d cs=%0d valid=%0d want 16/128/129", rises, cs_rise_k, valid_k); end
        checks++; if (sample_ch0 !== 12'hABC || sample_ch1 !== 12'hDEF || frame_err !== 1'b1) begin errors++; $display("FAIL drop_data: got %h/%h err=%b want abc/def/1", sample_ch0, sample_ch1, frame_err); end
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            if (cs_n !== 1'b1 || sclk !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL drop_idle: got %0d active cycles want 0", lows); end
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        enable = 1'b1;
        wait_cs_fall(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_frame_start: got timeout want cs_n fall"); end
        step(17);
        checks++; if (sample_valid !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL pre_reset: got v=%b sclk=%b want 1/0", sample_valid, sclk); end
        RST = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL async_rst_pins: got cs_n=%b sclk=%b want 1/1", cs_n, sclk); end
        checks++; if ({sample_valid, frame_err} !== 2'b00 || sample_ch0 !== 12'h000) begin errors++; $display("FAIL async_rst_regs: got v/e=%b ch0=%h want 00/000", {sample_valid, frame_err}, sample_ch0); end
        enable = 1'b0;
        step(2);
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_peak_hold();
        bit ok;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word0 = {4'h0, c_PK_S0[i]};
            word1 = {4'h0, c_PK_S1[i]};
            wait_cs_fall(ok);
            if (i == 3) begin
                step(128);
                peak_clr = 1'b1;
                step(1);
                peak_clr = 1'b0;
            end else begin
                step(129);
            end
            checks++; if (peak_ch0 !== c_EXP_PK0[i] || peak_ch1 !== c_EXP_PK1[i]) begin errors++; $display("FAIL peak_frame%0d: got %h/%h want %h/%h", i, peak_ch0, peak_ch1, c_EXP_PK0[i], c_EXP_PK1[i]); end
            ack_pulse();
        end
        peak_clr = 1'b1;
        step(1);
        peak_clr = 1'b0;
        checks++; if (peak_ch0 !== 12'h000 || peak_ch1 !== 12'h000) begin errors++; $display("FAIL peak_clr: got %h/%h want 000/000", peak_ch0, peak_ch1); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_frame_err();
        test_overrun();
        test_enable_drop();
        test_reset_mid_shift();
        test_peak_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
- Sequences dual-channel serial ADC conversions for the VU meter front end (PmodAD1 two channels / PmodMIC on channel 0).
- Runs from the 100 MHz board clock and generates CS and SCLK internally; no divided clock leaves the block.
- Shifts both data lines in together and delivers 12-bit samples to the meter logic with a valid/ack handshake at a fixed sample rate.

Parameters:
- CLK_DIV, 4: SCLK half-period in CLK cycles; 12.5 MHz SCLK at 100 MHz CLK.
- SAMPLE_PERIOD, 2500: CLK cycles between conversion starts (40 kHz). Must be ≥ 32*CLK_DIV+QUIET_CYCLES+2.
- QUIET_CYCLES, 4: minimum CLK cycles cs_n stays high after a frame.

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  asynchronous reset, active-high
- enable  in  1  run conversions while high
- sdata0  in  1  serial data, ADC channel 0
- sdata1  in  1  serial data, ADC channel 1
- sample_ack  in  1  consumer accepts current samples
- cs_n  out  1  ADC chip select, active-low
- sclk  out  1  ADC serial clock, idles high
- sample_ch0  out  12  last channel-0 result
- sample_ch1  out  12  last channel-1 result
- sample_valid  out  1  results pending
- overrun  out  1  sticky: a result was overwritten before ack
- frame_err  out  1  leading-zero violation in the last frame
- peak_clr  in  1  clear peak registers (optional feature)
- peak_ch0, peak_ch1  out  12  peak-hold values (optional feature)

Behaviour:
- Reset (async): cs_n=1, sclk=1, sample_ch0/1=0, sample_valid=0, overrun=0, frame_err=0, peaks=0, FSM=IDLE, period counter=0. A reset mid-frame aborts the frame immediately.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps while enable=1. It is held at 0 while enable=0. A tick fires on the cycle the counter equals SAMPLE_PERIOD-1.
- IDLE: enter ARM when enable=1.
- ARM: cs_n=1. On a tick, go to SHIFT, and cs_n falls the next cycle. With enable=0, return to IDLE. The first cs_n fall is SAMPLE_PERIOD cycles after enable is first sampled high.
- SHIFT: 16 bit slots, MSB first. Each slot has sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdata0/1 are sampled on the CLK edge where sclk goes high.
  - Bits 15..12 are leading zeros. Bits 11..0 are the sample.
  - Frame length is 32*CLK_DIV cycles (128 by default).
- End of frame: the cycle after the 16th sclk rise:
  - cs_n=1;
  - sample_ch0/1 load;
  - sample_valid=1;
  - frame_err = OR of the leading bits on either channel.
  - Latency from cs_n fall to sample_valid rise is 32*CLK_DIV+1 cycles.
- QUIET: cs_n=1 for QUIET_CYCLES cycles, then go to ARM, or IDLE if enable=0.
- Ticks that occur in SHIFT or QUIET are dropped; no catch-up conversion is issued.
- enable falling during SHIFT: the frame completes normally, then the FSM goes to IDLE after QUIET.
- Handshake:
  - sample_valid stays high until a cycle with sample_ack=1, then clears the next cycle.
  - sample_ack while sample_valid=0 is ignored.
  - Samples stay stable while valid.
- Overrun:
  - If a frame completes while sample_valid=1 and ack is not asserted that cycle, new data overwrites the old and overrun sets.
  - If ack and completion occur in the same cycle, valid stays 1, data updates and overrun is not set.
  - Overrun clears on the next accepted ack that does not coincide with a completion.
- frame_err is updated each completion and does not block data.

Optional Feature:
- Macro: ADC_PEAK_HOLD_EN.
- Defined: at each frame completion, peak_chN <= max(peak_chN, new sample_chN). On peak_clr, peak_chN clears to 0. If peak_clr coincides with a completion, peak_chN <= new sample.
- Undefined: peak_ch0/1 are tied to 0, peak_clr is ignored, and no peak registers are synthesized.

Test Plan:
- Reset then enable=1, defaults: cs_n falls 2500 cycles after enable; sclk toggles 16 times at a 4/4 duty; cs_n rises 128 cycles later.
- ADC model drives 0000_1010_1011_1100 (ch0) and 0000_0111_1111_1111 (ch1): sample_ch0=0xABC, sample_ch1=0x7FF, valid 129 cycles after cs_n fall, frame_err=0.
- Leading bits 0100 on ch1: frame_err=1, sample_ch1 = low 12 bits; next clean frame gives frame_err=0.
- Never ack across two frames: overrun=1, data = second frame. Ack on completion cycle: valid stays 1, overrun unchanged.
- Drop enable mid-SHIFT at slot 5: frame completes (16 sclk), then IDLE with cs_n=1. Assert RST mid-SHIFT: cs_n=1, sclk=1 and valid=0 immediately.
- ADC_PEAK_HOLD_EN: samples 0x100, 0x800, 0x300 → peak 0x800. peak_clr with sample 0x050 → peak 0x050.
